// File: rtl/pixel_ram_arbiter.sv
// Shares the single-port pixel RAM between the display scan (reads, front bank) and the host loader (writes, back bank).
// Latency: grant and RAM address are combinational; read data returns exactly 1 cycle after the read is issued.
// Backpressure: the display wins by default and the host sees o_wr_ready=0; after MAX_STALL blocked cycles the host is force-granted and the display read is dropped.
module pixel_ram_arbiter #(
    parameter int PIX_AW    = 11,
    parameter int DATA_W    = 24,
    parameter int MAX_STALL = 8
) (
    input  logic                i_clk,
    input  logic                rst,
    input  logic                i_disp_rd,
    input  logic [PIX_AW-1:0]   i_disp_addr,
    output logic [DATA_W-1:0]   o_disp_data,
    output logic                o_disp_valid,
    output logic                o_disp_miss,
    input  logic                i_disp_frame_end,
    input  logic                i_wr_valid,
    output logic                o_wr_ready,
    input  logic [PIX_AW-1:0]   i_wr_addr,
    input  logic [DATA_W-1:0]   i_wr_data,
    input  logic                i_swap_req,
    output logic                o_swap_pending,
    output logic                o_front_bank,
    output logic                o_ram_we,
    output logic [PIX_AW:0]     o_ram_addr,
    output logic [DATA_W-1:0]   o_ram_din,
    input  logic [DATA_W-1:0]   i_ram_dout
);

    // Counter only needs to reach MAX_STALL-1; keep at least one bit so MAX_STALL of 0 or 1 still elaborates.
    localparam int SW = (MAX_STALL > 1) ? $clog2(MAX_STALL) : 1;
    localparam logic [SW-1:0] STALL_LIM = SW'((MAX_STALL > 0) ? (MAX_STALL - 1) : 0);

    logic          force_q;
    logic [SW-1:0] stall_cnt;
    logic          front_bank;
    logic          swap_pending;
    logic          host_grant;
    logic          wr_blocked;

    assign o_front_bank   = front_bank;
    assign o_swap_pending = swap_pending;
    assign o_disp_data    = i_ram_dout;
    assign o_ram_din      = i_wr_data;
    assign wr_blocked     = i_wr_valid & ~o_wr_ready;

    // Per-cycle grant: a forced cycle belongs to the host, otherwise the display has priority.
    always_comb begin
        host_grant = force_q | ~i_disp_rd;
        o_wr_ready = ~rst & host_grant;
        o_ram_we   = ~rst & host_grant & i_wr_valid;
        o_ram_addr = o_ram_we ? {~front_bank, i_wr_addr} : {front_bank, i_disp_addr};
    end

    // Read status lags the request by one cycle to line up with the RAM's registered output.
    always_ff @(posedge i_clk) begin
        if (rst) begin
            o_disp_valid <= 1'b0;
            o_disp_miss  <= 1'b0;
        end else begin
            o_disp_valid <= i_disp_rd & ~force_q;
            o_disp_miss  <= i_disp_rd & force_q;
        end
    end

    // Starvation guard: count consecutive blocked host cycles and force a single host cycle at the limit.
    always_ff @(posedge i_clk) begin
        if (rst) begin
            force_q   <= 1'b0;
            stall_cnt <= '0;
        end else if (force_q) begin
            force_q   <= 1'b0;
            stall_cnt <= '0;
        end else if (wr_blocked && MAX_STALL > 0) begin
            if (stall_cnt == STALL_LIM) begin
                force_q   <= 1'b1;
                stall_cnt <= '0;
            end else begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end else begin
            stall_cnt <= '0;
        end
    end

    // Bank swap is deferred to a frame boundary; a request arriving with the boundary is honoured at once.
    always_ff @(posedge i_clk) begin
        if (rst) begin
            front_bank   <= 1'b0;
            swap_pending <= 1'b0;
        end else if (i_disp_frame_end && (swap_pending || i_swap_req)) begin
            front_bank   <= ~front_bank;
            swap_pending <= 1'b0;
        end else if (i_swap_req) begin
            swap_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pixel_ram_arbiter.sv
module tb_pixel_ram_arbiter;

    localparam int PIX_AW    = 11;
    localparam int DATA_W    = 24;
    localparam int MAX_STALL = 8;
    localparam int DEPTH     = 2 ** (PIX_AW + 1);

    logic                i_clk = 1'b0;
    logic                rst = 1'b1;
    logic                i_disp_rd = 1'b0;
    logic [PIX_AW-1:0]   i_disp_addr = '0;
    logic [DATA_W-1:0]   o_disp_data;
    logic                o_disp_valid;
    logic                o_disp_miss;
    logic                i_disp_frame_end = 1'b0;
    logic                i_wr_valid = 1'b0;
    logic                o_wr_ready;
    logic [PIX_AW-1:0]   i_wr_addr = '0;
    logic [DATA_W-1:0]   i_wr_data = '0;
    logic                i_swap_req = 1'b0;
    logic                o_swap_pending;
    logic                o_front_bank;
    logic                o_ram_we;
    logic [PIX_AW:0]     o_ram_addr;
    logic [DATA_W-1:0]   o_ram_din;
    logic [DATA_W-1:0]   i_ram_dout;

    pixel_ram_arbiter #(.PIX_AW(PIX_AW), .DATA_W(DATA_W), .MAX_STALL(MAX_STALL)) dut (
        .i_clk(i_clk), .rst(rst),
        .i_disp_rd(i_disp_rd), .i_disp_addr(i_disp_addr), .o_disp_data(o_disp_data),
        .o_disp_valid(o_disp_valid), .o_disp_miss(o_disp_miss), .i_disp_frame_end(i_disp_frame_end),
        .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
        .i_swap_req(i_swap_req), .o_swap_pending(o_swap_pending), .o_front_bank(o_front_bank),
        .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr), .o_ram_din(o_ram_din), .i_ram_dout(i_ram_dout)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural single-port synchronous RAM (read-before-write, 1-cycle read latency).
    logic [DATA_W-1:0] ram [DEPTH];
    always @(posedge i_clk) begin
        if (o_ram_we) ram[o_ram_addr] <= o_ram_din;
        i_ram_dout <= ram[o_ram_addr];
    end

    // Reference model: what the pixel RAM should contain, plus arbitration/bank state.
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int  m_front, m_pending, m_streak, m_force;

    typedef struct { bit miss; logic [DATA_W-1:0] data; } rd_exp_t;
    rd_exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every reported read result must match the oldest outstanding read.
    always @(negedge i_clk) begin
        if (o_disp_valid || o_disp_miss) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read_result: valid=%0b miss=%0b with no read outstanding", o_disp_valid, o_disp_miss);
            end else begin
                rd_exp_t e;
                e = sb.pop_front();
                chk("disp_valid", 64'(o_disp_valid), 64'(!e.miss));
                chk("disp_miss", 64'(o_disp_miss), 64'(e.miss));
                if (!e.miss) chk("disp_data", 64'(o_disp_data), 64'(e.data));
            end
        end
    end

    // One cycle of stimulus: drive, check combinational outputs against the model, then advance the model.
    task automatic run_cycle(input bit r, input bit rd, input bit wv, input bit fe, input bit sw);
        bit exp_ready, exp_we, prev_rst;
        logic [PIX_AW:0] exp_addr;
        rd_exp_t e;
        @(posedge i_clk);
        prev_rst = rst;
        #1;
        rst              = r;
        i_disp_rd        = rd;
        i_disp_addr      = PIX_AW'($urandom);
        i_wr_valid       = wv;
        i_wr_addr        = PIX_AW'($urandom);
        i_wr_data        = DATA_W'($urandom);
        i_disp_frame_end = fe;
        i_swap_req       = sw;

        exp_ready = !r && (m_force != 0 || !rd);
        exp_we    = exp_ready && wv;
        exp_addr  = exp_we ? {1'(!m_front), i_wr_addr} : {1'(m_front), i_disp_addr};

        @(negedge i_clk);
        chk("wr_ready", 64'(o_wr_ready), 64'(exp_ready));
        chk("ram_we", 64'(o_ram_we), 64'(exp_we));
        chk("ram_addr", 64'(o_ram_addr), 64'(exp_addr));
        if (exp_we) chk("ram_din", 64'(o_ram_din), 64'(i_wr_data));
        chk("front_bank", 64'(o_front_bank), 64'(m_front));
        chk("swap_pending", 64'(o_swap_pending), 64'(m_pending));
        if (prev_rst) begin
            chk("reset_valid", 64'(o_disp_valid), 64'(0));
            chk("reset_miss", 64'(o_disp_miss), 64'(0));
        end
        #1;
        if (rd && !r) begin
            e.miss = (m_force != 0);
            e.data = ref_mem[{1'(m_front), i_disp_addr}];
            sb.push_back(e);
        end
        if (exp_we) ref_mem[{1'(!m_front), i_wr_addr}] = i_wr_data;

        if (r) begin
            m_front = 0; m_pending = 0; m_streak = 0; m_force = 0;
        end else begin
            if (m_force != 0) begin
                m_force = 0; m_streak = 0;
            end else if (wv && !exp_ready) begin
                m_streak++;
                if (MAX_STALL > 0 && m_streak == MAX_STALL) begin
                    m_force = 1; m_streak = 0;
                end
            end else begin
                m_streak = 0;
            end
            if (fe && (m_pending != 0 || sw)) begin
                m_front = 1 - m_front; m_pending = 0;
            end else if (sw) begin
                m_pending = 1;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = DATA_W'($urandom);
            ref_mem[i] = ram[i];
        end
        m_front = 0; m_pending = 0; m_streak = 0; m_force = 0;

        // Reset, then a few directed patterns.
        run_cycle(1, 0, 0, 0, 0);
        run_cycle(1, 1, 1, 0, 0);
        run_cycle(0, 1, 0, 0, 0);
        run_cycle(0, 0, 1, 0, 0);
        // Display held busy while the host waits: exercises the force after MAX_STALL blocked cycles.
        for (int i = 0; i < 2 * MAX_STALL + 4; i++) run_cycle(0, 1, 1, 0, 0);
        // Swap request, later frame end; then simultaneous request and frame end with a write.
        run_cycle(0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) run_cycle(0, 1, 0, 0, 0);
        run_cycle(0, 0, 0, 1, 0);
        run_cycle(0, 0, 0, 1, 0);
        run_cycle(0, 0, 1, 1, 1);
        run_cycle(0, 1, 0, 0, 0);
        // Reset while a swap is pending and a force is about to fire.
        run_cycle(0, 0, 0, 0, 1);
        for (int i = 0; i < MAX_STALL; i++) run_cycle(0, 1, 1, 0, 0);
        run_cycle(1, 1, 1, 1, 0);
        run_cycle(0, 1, 0, 0, 0);

        // Randomized phases: balanced traffic, display-heavy contention, and swap-heavy traffic.
        for (int i = 0; i < 1500; i++)
            run_cycle($urandom_range(99) < 2, $urandom_range(1), $urandom_range(1),
                      $urandom_range(99) < 3, $urandom_range(99) < 5);
        for (int i = 0; i < 1500; i++)
            run_cycle($urandom_range(199) < 1, $urandom_range(99) < 92, $urandom_range(99) < 85,
                      $urandom_range(99) < 5, $urandom_range(99) < 5);
        for (int i = 0; i < 1000; i++)
            run_cycle($urandom_range(99) < 1, $urandom_range(99) < 70, $urandom_range(99) < 60,
                      $urandom_range(99) < 20, $urandom_range(99) < 20);
        // Read back both banks through the display path (front bank after each swap).
        for (int i = 0; i < 200; i++) run_cycle(0, 1, 0, 0, 0);
        run_cycle(0, 0, 0, 1, 1);
        for (int i = 0; i < 200; i++) run_cycle(0, 1, 0, 0, 0);

        run_cycle(0, 0, 0, 0, 0);
        run_cycle(0, 0, 0, 0, 0);
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
